// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
//   Converts a 14-bit binary sensor reading to 4-digit BCD with a sequential
//   double-dabble engine, then time-multiplexes the digits onto an
//   active-low common-anode style FND (one digit enabled per scan tick).
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   load      in   strobe, captures value (saturated to 9999)
//   value     in   14-bit unsigned reading
//   dp_mask   in   per-digit decimal point enable (bit0 = ones digit)
//   blank_lz  in   leading-zero blanking enable
//   busy      out  high while a conversion is running
//   fnd_com   out  digit enables, active-low
//   fnd_data  out  segments {dp,g,f,e,d,c,b,a}, active-low
module fnd_scan_controller #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [13:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        blank_lz,
    output logic        busy,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic {IDLE, CONV} state_t;

    state_t        state_q, state_d;
    logic [13:0]   bin_q, bin_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    iter_q, iter_d;
    logic          pend_vld_q, pend_vld_d;
    logic [13:0]   pend_q, pend_d;
    logic [15:0]   disp_q, disp_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    com_q, com_d;
    logic [7:0]    data_q, data_d;

    logic [15:0]   adj;
    logic [15:0]   shifted;
    logic          tick;
    logic          lz;
    logic [3:0]    digit;
    logic [7:0]    seg;

    function automatic logic [13:0] sat9999(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    // Add 3 to every nibble >= 5 so the following shift carries correctly.
    function automatic logic [15:0] dabble_adj(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Conversion FSM
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        disp_d     = disp_q;
        adj        = dabble_adj(bcd_q);
        shifted    = {adj[14:0], bin_q[13]};

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = CONV;
                    bin_d   = sat9999(value);
                    bcd_d   = 16'd0;
                    iter_d  = 4'd0;
                end
            end
            CONV: begin
                bcd_d  = shifted;
                bin_d  = {bin_q[12:0], 1'b0};
                iter_d = iter_q + 4'd1;
                if (load) begin
                    pend_vld_d = 1'b1;
                    pend_d     = sat9999(value);
                end
                if (iter_q == 4'd13) begin
                    // Whole result lands in one edge so a scan tick never sees a mix.
                    disp_d = shifted;
                    if (load || pend_vld_q) begin
                        // A load arriving on the completion edge is the newest value.
                        bin_d      = load ? sat9999(value) : pend_q;
                        bcd_d      = 16'd0;
                        iter_d     = 4'd0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit scan
    always_comb begin
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        com_d   = com_q;
        data_d  = data_q;
        digit   = disp_q[{idx_q, 2'b00} +: 4];

        case (idx_q)
            2'd1:    lz = (disp_q[15:4] == 12'd0);
            2'd2:    lz = (disp_q[15:8] == 8'd0);
            2'd3:    lz = (disp_q[15:12] == 4'd0);
            default: lz = 1'b0;
        endcase

        seg = (blank_lz && lz) ? 8'hFF : seg7(digit);
        if (dp_mask[idx_q]) seg[7] = 1'b0;

        if (tick) begin
            idx_d  = idx_q + 2'd1;
            com_d  = ~(4'b0001 << idx_q);
            data_d = seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
            disp_q     <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            com_q      <= 4'hF;
            data_q     <= 8'hFF;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            iter_q     <= iter_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            com_q      <= com_d;
            data_q     <= data_d;
        end
    end

    assign busy     = (state_q == CONV);
    assign fnd_com  = com_q;
    assign fnd_data = data_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value = 14'd0;
    logic [3:0]  dp_mask = 4'd0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    fnd_scan_controller #(.CLK_HZ(100), .SCAN_HZ(25)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .busy     (busy),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    // Edges since reset release; with DIV=4 ticks fall on multiples of 4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        do step(); while (cyc % 4 != 0);
    endtask

    task automatic show4(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        logic [3:0] ec;
        int i;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < 4; k++) begin
            tick();
            i  = ((cyc / 4) - 1) % 4;
            ec = ~(4'b0001 << i);
            chk({tag, "_com"}, fnd_com, ec);
            chk({tag, "_dat"}, fnd_data, e[i]);
        end
    endtask

    task automatic do_load(input logic [13:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            step();
        end
    endtask

    task automatic check_off(input string tag);
        for (int k = 0; k < 3; k++) begin
            step();
            chk({tag, "_offcom"}, fnd_com, 4'hF);
            chk({tag, "_offdat"}, fnd_data, 8'hFF);
        end
    endtask

    initial begin
        int   n;
        int   bc;
        logic saw2;

        repeat (2) step();
        chk("rst_com", fnd_com, 4'hF);
        chk("rst_dat", fnd_data, 8'hFF);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        check_off("rel1");
        step();
        chk("first_com", fnd_com, 4'hE);
        chk("first_dat", fnd_data, 8'hC0);

        do_load(14'd1234);
        busy_len(n);
        chk("busy1234", n, 14);
        show4("d1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

        blank_lz = 1'b1;
        dp_mask  = 4'b0010;
        do_load(14'd7);
        wait_idle("l7");
        show4("d7", 8'hF8, 8'h7F, 8'hFF, 8'hFF);

        dp_mask = 4'b0000;
        do_load(14'd0);
        wait_idle("l0");
        show4("d0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        blank_lz = 1'b0;
        do_load(14'h2EE0);
        wait_idle("lsat");
        show4("dsat", 8'h90, 8'h90, 8'h90, 8'h90);

        saw2 = 1'b0;
        do_load(14'd1111);
        bc = (busy === 1'b1) ? 1 : 0;
        for (int rel = 1; rel <= 40; rel++) begin
            if (rel == 3) begin
                value = 14'd2222;
                load  = 1'b1;
            end else if (rel == 5) begin
                value = 14'd3333;
                load  = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
            if (busy === 1'b1) bc++;
            if (fnd_data === 8'hA4) saw2 = 1'b1;
            if (cyc % 4 == 0 && rel >= 15 && rel <= 28) chk("mid1111", fnd_data, 8'hF9);
        end
        load = 1'b0;
        chk("busy_pend", bc, 28);
        chk("no2222", saw2, 1'b0);
        show4("d3333", 8'hB0, 8'hB0, 8'hB0, 8'hB0);

        do_load(14'd5678);
        repeat (7) step();
        chk("busy5678", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_com", fnd_com, 4'hF);
        chk("mrst_dat", fnd_data, 8'hFF);
        step();
        rst_n = 1'b1;
        check_off("rel2");
        chk("rel2_busy", busy, 1'b0);
        show4("dabort", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
